button_render_ctrl: RTL and testbench

- Sequences the shared button image ROM for a row of on-screen buttons in the VGA pixel pipeline.
- Decodes hcount/vcount against the button geometry and drives the ROM address. Button labels are stacked vertically in one ROM image.
- Overlays the ROM colour onto the incoming pixel stream, delaying all timing signals to match.
- Detects mouse clicks on buttons, emits a one-cycle press pulse, and flashes the pressed button (inverted colours) for a fixed time.

---
 rtl/button_render_ctrl_if.sv | 13 +
 rtl/button_render_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_button_render_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_render_ctrl_if.sv
// Pixel stream bundle for the VGA pipeline: coordinates, sync, blanking and colour.
interface button_render_ctrl_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/button_render_ctrl.sv
// Button row renderer: drives the shared label ROM, overlays it on the pixel
// stream with 2-cycle latency, and turns mouse clicks into press pulses + flash.
module button_render_ctrl #(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned BTN_X0          = 64,
    parameter int unsigned BTN_Y0          = 400,
    parameter int unsigned BTN_W           = 128,
    parameter int unsigned BTN_H           = 32,
    parameter int unsigned BTN_GAP         = 32,
    parameter int unsigned ROM_WIDTH_SIZE  = 8,
    parameter int unsigned ROM_HEIGHT_SIZE = 8,
    parameter int unsigned FLASH_CYCLES    = 6500000
) (
    input  logic                                     pclk,
    input  logic                                     rst_n,
    input  logic                                     enable,
    button_render_ctrl_if.slave                      vid_in,
    button_render_ctrl_if.master                     vid_out,
    input  logic [11:0]                              mouse_xpos,
    input  logic [11:0]                              mouse_ypos,
    input  logic                                     mouse_left,
    output logic [ROM_WIDTH_SIZE+ROM_HEIGHT_SIZE-1:0] rom_address,
    input  logic [11:0]                              rom_rgb,
    output logic [NUM_BTN-1:0]                       btn_pressed,
    output logic                                     busy
);

    localparam int unsigned ADDR_W = ROM_WIDTH_SIZE + ROM_HEIGHT_SIZE;
    localparam int unsigned IDX_W  = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int unsigned CNT_W  = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam int unsigned PITCH  = BTN_W + BTN_GAP;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLASH = 1'b1
    } state_t;

    function automatic int unsigned btn_left(input int unsigned idx);
        return BTN_X0 + idx * PITCH;
    endfunction

    // Returns {hit, index}; coordinates with bit 11 set are off-screen and never hit.
    function automatic logic [IDX_W:0] hit_test(input logic [11:0] x, input logic [11:0] y);
        logic [IDX_W:0] res;
        res = '0;
        if (!x[11] && !y[11] && (32'(y) >= BTN_Y0) && (32'(y) < BTN_Y0 + BTN_H)) begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if ((32'(x) >= btn_left(i)) && (32'(x) < btn_left(i) + BTN_W)) begin
                    res = {1'b1, IDX_W'(i)};
                end
            end
        end
        return res;
    endfunction

    logic [IDX_W:0]             w_pix_hit_res;
    logic                       w_pix_hit;
    logic [IDX_W-1:0]           w_pix_idx;
    logic [ROM_WIDTH_SIZE-1:0]  w_addrx;
    logic [ROM_HEIGHT_SIZE-1:0] w_addry;
    logic [IDX_W:0]             w_m_hit_res;
    logic                       w_m_hit;
    logic [IDX_W-1:0]           w_m_idx;
    logic                       w_click;

    always_comb begin
        w_pix_hit_res = hit_test({1'b0, vid_in.hcount}, {1'b0, vid_in.vcount});
        w_pix_hit     = w_pix_hit_res[IDX_W];
        w_pix_idx     = w_pix_hit_res[IDX_W-1:0];
        w_addrx       = ROM_WIDTH_SIZE'(32'(vid_in.hcount) - btn_left(32'(w_pix_idx)));
        w_addry       = ROM_HEIGHT_SIZE'(32'(w_pix_idx) * BTN_H + 32'(vid_in.vcount) - BTN_Y0);
        w_m_hit_res   = hit_test(mouse_xpos, mouse_ypos);
        w_m_hit       = w_m_hit_res[IDX_W];
        w_m_idx       = w_m_hit_res[IDX_W-1:0];
    end

    logic r_mouse_left_d;
    assign w_click = mouse_left & ~r_mouse_left_d;

    // Stage 1: decode geometry, address the ROM, delay the stream once.
    logic [10:0]       r_hcount_d1, r_vcount_d1;
    logic              r_hsync_d1, r_vsync_d1, r_hblnk_d1, r_vblnk_d1;
    logic [11:0]       r_rgb_d1;
    logic              r_hit_d1;
    logic [IDX_W-1:0]  r_idx_d1;
    logic [ADDR_W-1:0] r_rom_address;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount_d1   <= '0;
            r_vcount_d1   <= '0;
            r_hsync_d1    <= 1'b0;
            r_vsync_d1    <= 1'b0;
            r_hblnk_d1    <= 1'b0;
            r_vblnk_d1    <= 1'b0;
            r_rgb_d1      <= '0;
            r_hit_d1      <= 1'b0;
            r_idx_d1      <= '0;
            r_rom_address <= '0;
        end else begin
            r_hcount_d1 <= vid_in.hcount;
            r_vcount_d1 <= vid_in.vcount;
            r_hsync_d1  <= vid_in.hsync;
            r_vsync_d1  <= vid_in.vsync;
            r_hblnk_d1  <= vid_in.hblnk;
            r_vblnk_d1  <= vid_in.vblnk;
            r_rgb_d1    <= vid_in.rgb;
            r_hit_d1    <= w_pix_hit;
            r_idx_d1    <= w_pix_idx;
            if (w_pix_hit) begin
                r_rom_address <= {w_addry, w_addrx};
            end
        end
    end

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_flash_idx;
    logic               r_busy;
    logic [NUM_BTN-1:0] r_btn_pressed;

    // Stage 2: compose the pixel with the ROM data valid during stage 1.
    logic [10:0] r_hcount_d2, r_vcount_d2;
    logic        r_hsync_d2, r_vsync_d2, r_hblnk_d2, r_vblnk_d2;
    logic [11:0] r_rgb_out;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount_d2 <= '0;
            r_vcount_d2 <= '0;
            r_hsync_d2  <= 1'b0;
            r_vsync_d2  <= 1'b0;
            r_hblnk_d2  <= 1'b0;
            r_vblnk_d2  <= 1'b0;
            r_rgb_out   <= '0;
        end else begin
            r_hcount_d2 <= r_hcount_d1;
            r_vcount_d2 <= r_vcount_d1;
            r_hsync_d2  <= r_hsync_d1;
            r_vsync_d2  <= r_vsync_d1;
            r_hblnk_d2  <= r_hblnk_d1;
            r_vblnk_d2  <= r_vblnk_d1;
            if (r_hblnk_d1 || r_vblnk_d1) begin
                r_rgb_out <= '0;
            end else if (r_hit_d1 && (r_state == ST_FLASH) && (r_idx_d1 == r_flash_idx)) begin
                r_rgb_out <= ~rom_rgb;
            end else if (r_hit_d1) begin
                r_rgb_out <= rom_rgb;
            end else begin
                r_rgb_out <= r_rgb_d1;
            end
        end
    end

    // Click FSM: one press pulse on entry to FLASH; clicks ignored until the flash expires.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_flash_idx    <= '0;
            r_busy         <= 1'b0;
            r_btn_pressed  <= '0;
            r_mouse_left_d <= 1'b0;
        end else begin
            r_mouse_left_d <= mouse_left;
            r_btn_pressed  <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_click && enable && w_m_hit) begin
                        r_btn_pressed <= NUM_BTN'(1) << w_m_idx;
                        r_flash_idx   <= w_m_idx;
                        r_cnt         <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_FLASH;
                    end
                end
                ST_FLASH: begin
                    if (r_cnt == CNT_W'(FLASH_CYCLES - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_busy <= 1'b1;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vid_out.hcount = r_hcount_d2;
    assign vid_out.vcount = r_vcount_d2;
    assign vid_out.hsync  = r_hsync_d2;
    assign vid_out.vsync  = r_vsync_d2;
    assign vid_out.hblnk  = r_hblnk_d2;
    assign vid_out.vblnk  = r_vblnk_d2;
    assign vid_out.rgb    = r_rgb_out;
    assign rom_address    = r_rom_address;
    assign btn_pressed    = r_btn_pressed;
    assign busy           = r_busy;

endmodule

// File: tb/tb_button_render_ctrl.sv
// Directed bench for button_render_ctrl: geometry/address decode, overlay, click FSM, resets.
module tb_button_render_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic [15:0] rom_address;
    logic [11:0] rom_rgb;
    logic [3:0]  btn_pressed;
    logic        busy;

    int checks;
    int failures;
    int busy_cnt;

    button_render_ctrl_if vin ();
    button_render_ctrl_if vout ();

    button_render_ctrl #(.FLASH_CYCLES(10)) dut (
        .pclk        (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .vid_in      (vin),
        .vid_out     (vout),
        .mouse_xpos  (mouse_xpos),
        .mouse_ypos  (mouse_ypos),
        .mouse_left  (mouse_left),
        .rom_address (rom_address),
        .rom_rgb     (rom_rgb),
        .btn_pressed (btn_pressed),
        .busy        (busy)
    );

    // Simple ROM model: distinct colour per address.
    function automatic logic [11:0] rom_fn(input logic [15:0] a);
        return a[11:0] ^ {a[15:12], 8'h3C};
    endfunction

    assign rom_rgb = rom_fn(rom_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
    endtask

    task automatic set_pix(input int x, input int y, input logic hb, input logic [11:0] rgb);
        vin.hcount = 11'(x);
        vin.vcount = 11'(y);
        vin.hblnk  = hb;
        vin.vblnk  = 1'b0;
        vin.hsync  = 1'b1;
        vin.vsync  = 1'b0;
        vin.rgb    = rgb;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({rom_address, vout.rgb, btn_pressed, busy} !== 33'd0) begin
            failures++;
            $display("FAIL reset_init: rom=%h rgb=%h btn=%b busy=%b required all 0", rom_address, vout.rgb, btn_pressed, busy);
        end
        step();
        rst_n = 1'b1;
        set_pix(224, 410, 1'b0, 12'h111);
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_address, vout.rgb, vout.hcount, vout.hsync, btn_pressed, busy} !== 46'd0) begin
            failures++;
            $display("FAIL reset_async: rom=%h rgb=%h hc=%0d hs=%b required all 0", rom_address, vout.rgb, vout.hcount, vout.hsync);
        end
        step();
        rst_n = 1'b1;
        set_pix(10, 10, 1'b0, 12'hABC);
        step(); step();
        checks++;
        if (vout.rgb !== 12'hABC || vout.hcount !== 11'd10 || vout.hsync !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_pixel: rgb=%h hc=%0d hs=%b required rgb=abc hc=10 hs=1", vout.rgb, vout.hcount, vout.hsync);
        end
    endtask

    task automatic test_address;
        set_pix(224, 410, 1'b0, 12'h222);
        step();
        checks++;
        if (rom_address !== 16'h2A00) begin
            failures++;
            $display("FAIL addr_btn1: got %h required 2a00", rom_address);
        end
        set_pix(10, 10, 1'b0, 12'h333);
        step();
        checks++;
        if (vout.rgb !== rom_fn(16'h2A00) || vout.hcount !== 11'd224 || vout.vcount !== 11'd410) begin
            failures++;
            $display("FAIL rgb_btn1: rgb=%h hc=%0d vc=%0d required %h 224 410", vout.rgb, vout.hcount, vout.vcount, rom_fn(16'h2A00));
        end
        checks++;
        if (rom_address !== 16'h2A00) begin
            failures++;
            $display("FAIL addr_hold: got %h required 2a00", rom_address);
        end
        set_pix(64, 400, 1'b0, 12'h444);
        step();
        checks++;
        if (rom_address !== 16'h0000) begin
            failures++;
            $display("FAIL addr_btn0: got %h required 0000", rom_address);
        end
        step();
        checks++;
        if (vout.rgb !== rom_fn(16'h0000)) begin
            failures++;
            $display("FAIL rgb_btn0: got %h required %h", vout.rgb, rom_fn(16'h0000));
        end
    endtask

    task automatic test_edges;
        set_pix(191, 400, 1'b0, 12'h555);
        step();
        checks++;
        if (rom_address !== 16'h007F) begin
            failures++;
            $display("FAIL edge_x191_addr: got %h required 007f", rom_address);
        end
        step();
        checks++;
        if (vout.rgb !== rom_fn(16'h007F)) begin
            failures++;
            $display("FAIL edge_x191_rgb: got %h required %h", vout.rgb, rom_fn(16'h007F));
        end
        set_pix(192, 400, 1'b0, 12'h123);
        step(); step();
        checks++;
        if (vout.rgb !== 12'h123) begin
            failures++;
            $display("FAIL edge_x192: got %h required 123", vout.rgb);
        end
        set_pix(100, 432, 1'b0, 12'h456);
        step(); step();
        checks++;
        if (vout.rgb !== 12'h456) begin
            failures++;
            $display("FAIL edge_y432: got %h required 456", vout.rgb);
        end
        set_pix(100, 399, 1'b0, 12'h789);
        step(); step();
        checks++;
        if (vout.rgb !== 12'h789) begin
            failures++;
            $display("FAIL edge_y399: got %h required 789", vout.rgb);
        end
        set_pix(100, 410, 1'b1, 12'hFFF);
        step(); step();
        checks++;
        if (vout.rgb !== 12'h000 || vout.hblnk !== 1'b1) begin
            failures++;
            $display("FAIL hblnk_in_button: rgb=%h hblnk=%b required 000 1", vout.rgb, vout.hblnk);
        end
    endtask

    task automatic test_click_flash;
        int guard;
        set_pix(10, 10, 1'b0, 12'h000);
        enable     = 1'b1;
        mouse_xpos = 12'd300;
        mouse_ypos = 12'd415;
        mouse_left = 1'b0;
        step();
        busy_cnt   = 0;
        mouse_left = 1'b1;
        step();
        checks++;
        if (btn_pressed !== 4'b0010 || busy !== 1'b1) begin
            failures++;
            $display("FAIL click_pulse: btn=%b busy=%b required 0010 1", btn_pressed, busy);
        end
        set_pix(230, 405, 1'b0, 12'h000);
        step(); step();
        checks++;
        if (vout.rgb !== ~rom_fn(16'h2506) || btn_pressed !== 4'b0000) begin
            failures++;
            $display("FAIL flash_invert: rgb=%h btn=%b required %h 0000", vout.rgb, btn_pressed, ~rom_fn(16'h2506));
        end
        set_pix(70, 405, 1'b0, 12'h000);
        step(); step();
        checks++;
        if (vout.rgb !== rom_fn(16'h0506)) begin
            failures++;
            $display("FAIL flash_other_btn: rgb=%h required %h", vout.rgb, rom_fn(16'h0506));
        end
        mouse_left = 1'b0;
        step();
        mouse_left = 1'b1;
        step();
        checks++;
        if (btn_pressed !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL click_during_flash: btn=%b busy=%b required 0000 1", btn_pressed, busy);
        end
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (busy !== 1'b0 || busy_cnt != 10) begin
            failures++;
            $display("FAIL flash_length: busy=%b high_cycles=%0d required 0 10", busy, busy_cnt);
        end
    endtask

    task automatic test_no_click;
        // mouse_left still held from the previous press
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (btn_pressed !== 4'b0000 || busy !== 1'b0) begin
                failures++;
                $display("FAIL held_button: btn=%b busy=%b required 0000 0", btn_pressed, busy);
            end
        end
        mouse_left = 1'b0;
        enable     = 1'b0;
        step();
        mouse_left = 1'b1;
        step();
        checks++;
        if (btn_pressed !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL click_disabled: btn=%b busy=%b required 0000 0", btn_pressed, busy);
        end
        enable     = 1'b1;
        mouse_left = 1'b0;
        mouse_xpos = 12'd200;
        step();
        mouse_left = 1'b1;
        step();
        checks++;
        if (btn_pressed !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL click_gap: btn=%b busy=%b required 0000 0", btn_pressed, busy);
        end
        mouse_left = 1'b0;
        mouse_xpos = 12'd2348;
        step();
        mouse_left = 1'b1;
        step();
        checks++;
        if (btn_pressed !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL click_offscreen_x: btn=%b busy=%b required 0000 0", btn_pressed, busy);
        end
    endtask

    task automatic test_reset_flash;
        int guard;
        mouse_left = 1'b0;
        mouse_xpos = 12'd300;
        mouse_ypos = 12'd415;
        step();
        mouse_left = 1'b1;
        step();
        checks++;
        if (btn_pressed !== 4'b0010) begin
            failures++;
            $display("FAIL reflash_pulse: btn=%b required 0010", btn_pressed);
        end
        step(); step(); step(); step(); step();
        #2 rst_n = 1'b0;
        mouse_left = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || btn_pressed !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_flash: busy=%b btn=%b required 0 0000", busy, btn_pressed);
        end
        step();
        rst_n      = 1'b1;
        mouse_xpos = 12'd400;
        mouse_ypos = 12'd420;
        step();
        checks++;
        if (busy !== 1'b0 || btn_pressed !== 4'b0000) begin
            failures++;
            $display("FAIL after_reset_idle: busy=%b btn=%b required 0 0000", busy, btn_pressed);
        end
        mouse_left = 1'b1;
        step();
        checks++;
        if (btn_pressed !== 4'b0100 || busy !== 1'b1) begin
            failures++;
            $display("FAIL click_after_reset: btn=%b busy=%b required 0100 1", btn_pressed, busy);
        end
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flash_timeout: busy=%b required 0", busy);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        busy_cnt   = 0;
        enable     = 1'b0;
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        mouse_left = 1'b0;
        set_pix(0, 0, 1'b0, 12'h000);
        test_reset();
        test_address();
        test_edges();
        test_click_flash();
        test_no_click();
        test_reset_flash();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
